single_cycle_cpu: RTL and testbench

//  Single-cycle RV32I subset processor core: one instruction fetched, decoded, executed and retired per clock.

---
 rtl/single_cycle_cpu.sv | 241 ++++++++++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
// Single-cycle RV32I subset core: fetch, decode, execute and retire
// one instruction per clock; all state lives in internal arrays.

module register_file (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

    // No reset clear: preloaded contents must survive reset.
    always_ff @(posedge clock) begin
        if (reset && we && (wa != 5'd0))
            registers[wa] <= wd;
    end
endmodule

module ins_memory #(
    parameter int DEPTH = 256
) (
    input  logic [29:0] waddr,
    output logic [31:0] instr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] memory [0:DEPTH-1];

    assign instr = memory[AW'(waddr % 30'(DEPTH))];
endmodule

module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we,
    input  logic [29:0] waddr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] memory [0:DEPTH-1];
    logic [AW-1:0] idx;

    assign idx = AW'(waddr % 30'(DEPTH));
    assign rd  = memory[idx];

    always_ff @(posedge clock) begin
        if (reset && we)
            memory[idx] <= wd;
    end
endmodule

module single_cycle_cpu #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clock,
    input logic reset
);
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] load_data;
    logic [31:0] wb;
    logic        taken;

    logic is_op, is_opimm, is_load, is_store;
    logic is_branch, is_jal, is_jalr, is_lui, is_auipc;

    logic       rf_we;
    logic       mem_we;
    logic       use_imm;
    logic [2:0] alu_f3;
    logic       alu_alt;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);

    ins_memory #(.DEPTH(IMEM_DEPTH)) ins_memory_module (
        .waddr (pc[31:2]),
        .instr (instr)
    );

    register_file register_file_module (
        .clock (clock),
        .reset (reset),
        .we    (rf_we),
        .ra1   (rs1),
        .ra2   (rs2),
        .wa    (rd),
        .wd    (wb),
        .rd1   (rs1_v),
        .rd2   (rs2_v)
    );

    data_memory #(.DEPTH(DMEM_DEPTH)) data_memory_module (
        .clock (clock),
        .reset (reset),
        .we    (mem_we),
        .waddr (alu_y[31:2]),
        .wd    (rs2_v),
        .rd    (load_data)
    );

    // Non-ALU instructions fall through to a plain add for addresses.
    always_comb begin
        rf_we   = 1'b0;
        mem_we  = 1'b0;
        use_imm = 1'b0;
        alu_f3  = 3'b000;
        alu_alt = 1'b0;
        unique case (1'b1)
            is_op: begin
                rf_we   = 1'b1;
                alu_f3  = f3;
                alu_alt = instr[30];
            end
            is_opimm: begin
                rf_we   = 1'b1;
                use_imm = 1'b1;
                alu_f3  = f3;
                alu_alt = (f3 == 3'b101) && instr[30];
            end
            is_load: begin
                rf_we   = 1'b1;
                use_imm = 1'b1;
            end
            is_store: begin
                mem_we  = 1'b1;
                use_imm = 1'b1;
            end
            is_jalr: begin
                rf_we   = 1'b1;
                use_imm = 1'b1;
            end
            is_jal:   rf_we = 1'b1;
            is_lui:   rf_we = 1'b1;
            is_auipc: rf_we = 1'b1;
            default: ;
        endcase
    end

    assign alu_b = !use_imm ? rs2_v :
                   is_store ? imm_s : imm_i;

    always_comb begin
        case (alu_f3)
            3'b000:  alu_y = alu_alt ? rs1_v - alu_b
                                     : rs1_v + alu_b;
            3'b001:  alu_y = rs1_v << alu_b[4:0];
            3'b010:  alu_y = {31'd0,
                              $signed(rs1_v) < $signed(alu_b)};
            3'b011:  alu_y = {31'd0, rs1_v < alu_b};
            3'b100:  alu_y = rs1_v ^ alu_b;
            3'b101:  alu_y = alu_alt
                     ? $unsigned($signed(rs1_v) >>> alu_b[4:0])
                     : rs1_v >> alu_b[4:0];
            3'b110:  alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  taken = (rs1_v == rs2_v);
            3'b001:  taken = (rs1_v != rs2_v);
            3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
            3'b101:  taken = $signed(rs1_v) >= $signed(rs2_v);
            3'b110:  taken = rs1_v < rs2_v;
            3'b111:  taken = rs1_v >= rs2_v;
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc + 32'd4;

    assign wb = is_load              ? load_data :
                (is_jal || is_jalr)  ? pc_plus4 :
                is_lui               ? imm_u :
                is_auipc             ? pc + imm_u :
                alu_y;

    assign next_pc = (is_branch && taken) ? pc + imm_b :
                     is_jal               ? pc + imm_j :
                     is_jalr              ? alu_y & ~32'd1 :
                     pc_plus4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pc <= 32'd0;
        else
            pc <= next_pc;
    end
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: directed reset/preload checks plus
// random programs run in lockstep with an instruction-level model.

module tb_single_cycle_cpu;
    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;

    typedef enum int {
        K_ADD, K_SUB, K_AND, K_OR, K_XOR,
        K_SLL, K_SRL, K_SRA, K_SLT, K_SLTU,
        K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI,
        K_SLTIU, K_SLLI, K_SRLI, K_SRAI,
        K_LW, K_SW,
        K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
        K_JAL, K_JALR, K_LUI, K_AUIPC
    } kind_e;

    typedef struct {
        kind_e       k;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } ins_t;

    ins_t        prog  [0:63];
    logic [31:0] m_reg [0:31];
    logic [31:0] m_mem [0:255];
    logic [31:0] m_pc;

    single_cycle_cpu dut (
        .clock (clock),
        .reset (reset)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic ins_t mk(kind_e k, int rd, int rs1,
                                int rs2, logic [31:0] imm);
        ins_t x;
        x.k   = k;
        x.rd  = 5'(rd);
        x.rs1 = 5'(rs1);
        x.rs2 = 5'(rs2);
        x.imm = imm;
        return x;
    endfunction

    function automatic logic [31:0] rt(logic [6:0] f7,
                                       logic [2:0] f3, ins_t x);
        return {f7, x.rs2, x.rs1, f3, x.rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(logic [2:0] f3, ins_t x,
                                       logic [6:0] op);
        return {x.imm[11:0], x.rs1, f3, x.rd, op};
    endfunction

    function automatic logic [31:0] bt(logic [2:0] f3, ins_t x);
        return {x.imm[12], x.imm[10:5], x.rs2, x.rs1, f3,
                x.imm[4:1], x.imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc(ins_t x);
        case (x.k)
            K_ADD:   return rt(7'h00, 3'd0, x);
            K_SUB:   return rt(7'h20, 3'd0, x);
            K_AND:   return rt(7'h00, 3'd7, x);
            K_OR:    return rt(7'h00, 3'd6, x);
            K_XOR:   return rt(7'h00, 3'd4, x);
            K_SLL:   return rt(7'h00, 3'd1, x);
            K_SRL:   return rt(7'h00, 3'd5, x);
            K_SRA:   return rt(7'h20, 3'd5, x);
            K_SLT:   return rt(7'h00, 3'd2, x);
            K_SLTU:  return rt(7'h00, 3'd3, x);
            K_ADDI:  return it(3'd0, x, 7'b0010011);
            K_ANDI:  return it(3'd7, x, 7'b0010011);
            K_ORI:   return it(3'd6, x, 7'b0010011);
            K_XORI:  return it(3'd4, x, 7'b0010011);
            K_SLTI:  return it(3'd2, x, 7'b0010011);
            K_SLTIU: return it(3'd3, x, 7'b0010011);
            K_SLLI:  return it(3'd1, x, 7'b0010011);
            K_SRLI:  return it(3'd5, x, 7'b0010011);
            K_SRAI:  return {7'h20, x.imm[4:0], x.rs1, 3'd5,
                             x.rd, 7'b0010011};
            K_LW:    return it(3'd2, x, 7'b0000011);
            K_SW:    return {x.imm[11:5], x.rs2, x.rs1, 3'd2,
                             x.imm[4:0], 7'b0100011};
            K_BEQ:   return bt(3'd0, x);
            K_BNE:   return bt(3'd1, x);
            K_BLT:   return bt(3'd4, x);
            K_BGE:   return bt(3'd5, x);
            K_BLTU:  return bt(3'd6, x);
            K_BGEU:  return bt(3'd7, x);
            K_JAL:   return {x.imm[20], x.imm[10:1], x.imm[11],
                             x.imm[19:12], x.rd, 7'b1101111};
            K_JALR:  return it(3'd0, x, 7'b1100111);
            K_LUI:   return {x.imm[31:12], x.rd, 7'b0110111};
            default: return {x.imm[31:12], x.rd, 7'b0010111};
        endcase
    endfunction

    // Architectural effect of one instruction on the model state.
    task automatic model_step();
        ins_t        x;
        logic [31:0] a, b, res, npc, ea;
        bit          wr;
        x   = prog[m_pc >> 2];
        a   = m_reg[x.rs1];
        b   = m_reg[x.rs2];
        res = 32'd0;
        npc = m_pc + 32'd4;
        wr  = 1'b1;
        ea  = a + x.imm;
        case (x.k)
            K_ADD:   res = a + b;
            K_SUB:   res = a - b;
            K_AND:   res = a & b;
            K_OR:    res = a | b;
            K_XOR:   res = a ^ b;
            K_SLL:   res = a << b[4:0];
            K_SRL:   res = a >> b[4:0];
            K_SRA:   res = $signed(a) >>> b[4:0];
            K_SLT:   res = ($signed(a) < $signed(b)) ? 1 : 0;
            K_SLTU:  res = (a < b) ? 1 : 0;
            K_ADDI:  res = a + x.imm;
            K_ANDI:  res = a & x.imm;
            K_ORI:   res = a | x.imm;
            K_XORI:  res = a ^ x.imm;
            K_SLTI:  res = ($signed(a) < $signed(x.imm)) ? 1 : 0;
            K_SLTIU: res = (a < x.imm) ? 1 : 0;
            K_SLLI:  res = a << x.imm[4:0];
            K_SRLI:  res = a >> x.imm[4:0];
            K_SRAI:  res = $signed(a) >>> x.imm[4:0];
            K_LW:    res = m_mem[(ea >> 2) % 256];
            K_SW: begin
                m_mem[(ea >> 2) % 256] = b;
                wr = 1'b0;
            end
            K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU: begin
                wr = 1'b0;
                if ((x.k == K_BEQ  && a == b) ||
                    (x.k == K_BNE  && a != b) ||
                    (x.k == K_BLT  && $signed(a) <  $signed(b)) ||
                    (x.k == K_BGE  && $signed(a) >= $signed(b)) ||
                    (x.k == K_BLTU && a <  b) ||
                    (x.k == K_BGEU && a >= b))
                    npc = m_pc + x.imm;
            end
            K_JAL: begin
                res = m_pc + 32'd4;
                npc = m_pc + x.imm;
            end
            K_JALR: begin
                res = m_pc + 32'd4;
                npc = ea & ~32'd1;
            end
            K_LUI:   res = x.imm;
            default: res = m_pc + x.imm;
        endcase
        if (wr && x.rd != 5'd0)
            m_reg[x.rd] = res;
        m_pc = npc;
    endtask

    task automatic chk(string tag, logic [31:0] got,
                       logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Forward-only control flow, so every program reaches the
    // closing self-loop within n cycles.
    task automatic gen_prog(int n);
        for (int i = 0; i < n - 1; i++) begin
            ins_t        x;
            logic [11:0] s12;
            logic [31:0] u;
            int          t;
            x.k   = kind_e'($urandom_range(0, 30));
            x.rd  = 5'($urandom_range(0, 31));
            x.rs1 = 5'($urandom_range(0, 31));
            x.rs2 = 5'($urandom_range(0, 31));
            s12   = 12'($urandom_range(0, 4095));
            u     = $urandom;
            x.imm = {{20{s12[11]}}, s12};
            t     = $urandom_range(i + 1,
                        (i + 4 < n - 1) ? i + 4 : n - 1);
            case (x.k)
                K_SLLI, K_SRLI, K_SRAI:
                    x.imm = 32'($urandom_range(0, 31));
                K_LUI, K_AUIPC:
                    x.imm = {u[31:12], 12'd0};
                K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU, K_JAL:
                    x.imm = 32'((t - i) * 4);
                K_JALR: begin
                    x.rs1 = 5'd0;
                    x.imm = 32'(t * 4 + $urandom_range(0, 1));
                end
                default: ;
            endcase
            prog[i] = x;
        end
        prog[n-1] = mk(K_JAL, 0, 0, 0, 32'd0);
    endtask

    task automatic run_random(int n);
        reset = 1'b0;
        gen_prog(n);
        for (int i = 0; i < n; i++)
            dut.ins_memory_module.memory[i] = enc(prog[i]);
        m_reg[0] = 32'd0;
        dut.register_file_module.registers[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            m_reg[i] = $urandom;
            dut.register_file_module.registers[i] = m_reg[i];
        end
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = $urandom;
            dut.data_memory_module.memory[i] = m_mem[i];
        end
        m_pc = 32'd0;
        @(negedge clock);
        chk("rnd_rst_pc", dut.pc, 32'd0);
        reset = 1'b1;
        for (int c = 0; c < n + 10; c++) begin
            model_step();
            @(negedge clock);
            chk("rnd_pc", dut.pc, m_pc);
        end
        for (int i = 0; i < 32; i++)
            chk($sformatf("rnd_x%0d", i),
                dut.register_file_module.registers[i], m_reg[i]);
        for (int i = 0; i < 256; i++)
            chk($sformatf("rnd_dmem%0d", i),
                dut.data_memory_module.memory[i], m_mem[i]);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 32; i++)
            dut.register_file_module.registers[i] = 32'd0;
        dut.register_file_module.registers[2] = 32'd100;
        dut.register_file_module.registers[8] = 32'd700;
        for (int i = 0; i < 256; i++)
            dut.data_memory_module.memory[i] = 32'd0;
        dut.data_memory_module.memory[0] = 32'd5;
        dut.data_memory_module.memory[1] = 32'd10;
        dut.data_memory_module.memory[2] = 32'd20;
        dut.data_memory_module.memory[3] = 32'd30;
        dut.data_memory_module.memory[4] = 32'd40;
        dut.ins_memory_module.memory[0] =
            enc(mk(K_ADDI, 2, 2, 0, -32));
        dut.ins_memory_module.memory[1] =
            enc(mk(K_SW, 0, 2, 8, 32'd44));
        dut.ins_memory_module.memory[2] =
            enc(mk(K_ADDI, 8, 2, 0, 32'd48));
        dut.ins_memory_module.memory[3] =
            enc(mk(K_ADDI, 0, 0, 0, 32'd5));
        dut.ins_memory_module.memory[4] =
            enc(mk(K_LW, 5, 0, 0, 32'd9));
        dut.ins_memory_module.memory[5] =
            enc(mk(K_JAL, 0, 0, 0, 32'd0));

        @(negedge clock);
        chk("rst_pc", dut.pc, 32'd0);
        chk("rst_x2", dut.register_file_module.registers[2], 32'd100);
        chk("rst_x8", dut.register_file_module.registers[8], 32'd700);
        chk("rst_dmem0", dut.data_memory_module.memory[0], 32'd5);
        chk("rst_dmem4", dut.data_memory_module.memory[4], 32'd40);
        reset = 1'b1;

        repeat (3) @(negedge clock);
        chk("x2_after3", dut.register_file_module.registers[2], 32'd68);
        chk("dmem28", dut.data_memory_module.memory[28], 32'd700);
        chk("x8_after3", dut.register_file_module.registers[8], 32'd116);
        chk("pc_after3", dut.pc, 32'd12);

        repeat (2) @(negedge clock);
        chk("x0_ignored", dut.register_file_module.registers[0], 32'd0);
        chk("lw_misalign", dut.register_file_module.registers[5], 32'd20);
        chk("pc_loop", dut.pc, 32'd20);
        repeat (5) @(negedge clock);
        chk("pc_loop_hold", dut.pc, 32'd20);
        chk("x1_zero", dut.register_file_module.registers[1], 32'd0);
        chk("dmem2_kept", dut.data_memory_module.memory[2], 32'h14);

        reset = 1'b0;
        for (int i = 0; i < 16; i++)
            dut.ins_memory_module.memory[i] =
                enc(mk(K_ADDI, 7, 7, 0, 32'd1));
        dut.register_file_module.registers[7] = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("cnt3", dut.register_file_module.registers[7], 32'd3);
        chk("cnt_pc", dut.pc, 32'd12);
        #2 reset = 1'b0;
        #1;
        chk("async_pc", dut.pc, 32'd0);
        chk("async_x7", dut.register_file_module.registers[7], 32'd3);
        @(negedge clock);
        chk("held_pc", dut.pc, 32'd0);
        chk("held_x7", dut.register_file_module.registers[7], 32'd3);
        reset = 1'b1;
        @(negedge clock);
        chk("resume_x7", dut.register_file_module.registers[7], 32'd4);
        chk("resume_pc", dut.pc, 32'd4);

        run_random(40);
        run_random(60);
        run_random(64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
